// File: rtl/gps_quantizer_agc_if.sv
// Sample/control bundle between the baseband source and the 3-bit quantizer/AGC.
// The master drives samples and AGC settings; the slave returns codes and loop status.
interface gps_quantizer_agc_if #(
    parameter int WIN_LOG2 = 10
);
    logic                    enable;
    logic signed [15:0]      in_real;
    logic signed [15:0]      in_imag;
    logic                    agc_enable;
    logic [15:0]             manual_thresh;
    logic [WIN_LOG2+1:0]     agc_target;
    logic [WIN_LOG2+1:0]     agc_hyst;
    logic [2:0]              real_out;
    logic [2:0]              imag_out;
    logic                    out_valid;
    logic [15:0]             thresh;
    logic                    agc_locked;

    modport master (
        output enable, in_real, in_imag, agc_enable, manual_thresh, agc_target, agc_hyst,
        input  real_out, imag_out, out_valid, thresh, agc_locked
    );

    modport slave (
        input  enable, in_real, in_imag, agc_enable, manual_thresh, agc_target, agc_hyst,
        output real_out, imag_out, out_valid, thresh, agc_locked
    );
endinterface

// File: rtl/gps_quantizer_agc.sv
// 3-bit sign-magnitude I/Q quantizer with a top-bin-occupancy AGC loop on the step T.
// Two-stage datapath: stage 1 takes sign/|x| and T,2T,3T; stage 2 bins |x|.
// The AGC counts top-bin hits on the registered stage-2 codes and nudges T once per window.
module gps_quantizer_agc #(
    parameter int WIN_LOG2     = 10,
    parameter int T_INIT       = 2048,
    parameter int T_MIN        = 16,
    parameter int T_MAX        = 32767,
    parameter int STEP_SHIFT   = 4,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic               clk,
    input  logic               rstn,
    gps_quantizer_agc_if.slave bus
);
    localparam int CW = WIN_LOG2 + 2;
    localparam int LW = $clog2(LOCK_WINDOWS + 1);
    localparam logic signed [17:0] T_MIN_S = 18'(T_MIN);
    localparam logic signed [17:0] T_MAX_S = 18'(T_MAX);
    localparam logic [LW-1:0]      LOCK_N  = LW'(LOCK_WINDOWS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Magnitude bin; landing exactly on a threshold selects the higher bin.
    function automatic logic [1:0] quant_mag(input logic [15:0] a,
                                             input logic [17:0] t1,
                                             input logic [17:0] t2,
                                             input logic [17:0] t3);
        logic [17:0] ax;
        logic [1:0]  m;
        ax = {2'b00, a};
        if (ax >= t3) begin
            m = 2'd3;
        end else if (ax >= t2) begin
            m = 2'd2;
        end else if (ax >= t1) begin
            m = 2'd1;
        end else begin
            m = 2'd0;
        end
        return m;
    endfunction

    // Clamp a candidate step (may be negative or above 16 bits) into [T_MIN, T_MAX].
    function automatic logic [15:0] clamp_t(input logic signed [17:0] v);
        logic [15:0] r;
        if (v < T_MIN_S) begin
            r = 16'(T_MIN);
        end else if (v > T_MAX_S) begin
            r = 16'(T_MAX);
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // Stage 1 registers
    logic                 s1_valid_q;
    logic                 s1_sign_re_q;
    logic                 s1_sign_im_q;
    logic [15:0]          s1_abs_re_q;
    logic [15:0]          s1_abs_im_q;
    logic [17:0]          s1_t1_q;
    logic [17:0]          s1_t2_q;
    logic [17:0]          s1_t3_q;
    // Stage 2 registers
    logic [2:0]           real_q;
    logic [2:0]           imag_q;
    logic                 valid_q;
    // AGC state
    state_e               state_q, state_d;
    logic [15:0]          t_q, t_d;
    logic                 locked_q, locked_d;
    logic [LW-1:0]        lock_cnt_q, lock_cnt_d;
    logic [WIN_LOG2-1:0]  win_cnt_q, win_cnt_d;
    logic [CW-1:0]        evt_cnt_q, evt_cnt_d;
    // Combinational helpers
    logic [15:0]          abs_re_s;
    logic [15:0]          abs_im_s;
    logic [CW-1:0]        evt_sum_s;
    logic [CW:0]          hi_s;
    logic [CW-1:0]        lo_s;
    logic                 above_s;
    logic                 below_s;
    logic [15:0]          t_shr_s;
    logic [15:0]          d_s;
    logic signed [17:0]   t_up_s;
    logic signed [17:0]   t_dn_s;
    logic [LW-1:0]        lock_inc_s;

    // |-32768| wraps to 0x8000, which read unsigned is exactly 32768.
    assign abs_re_s = bus.in_real[15] ? 16'(~bus.in_real + 16'd1) : $unsigned(bus.in_real);
    assign abs_im_s = bus.in_imag[15] ? 16'(~bus.in_imag + 16'd1) : $unsigned(bus.in_imag);

    // Running event count including the sample currently on the stage-2 outputs.
    assign evt_sum_s = evt_cnt_q + CW'(real_q[1:0] == 2'b11) + CW'(imag_q[1:0] == 2'b11);

    // Deadband edges; the lower edge floors at zero rather than wrapping.
    assign hi_s    = {1'b0, bus.agc_target} + {1'b0, bus.agc_hyst};
    assign lo_s    = (bus.agc_target > bus.agc_hyst) ? (bus.agc_target - bus.agc_hyst) : {CW{1'b0}};
    assign above_s = ({1'b0, evt_sum_s} > hi_s);
    assign below_s = (evt_sum_s < lo_s);

    // Proportional step with a floor of 1 so small T can still move.
    assign t_shr_s    = t_q >> STEP_SHIFT;
    assign d_s        = (t_shr_s == 16'd0) ? 16'd1 : t_shr_s;
    assign t_up_s     = $signed({2'b00, t_q}) + $signed({2'b00, d_s});
    assign t_dn_s     = $signed({2'b00, t_q}) - $signed({2'b00, d_s});
    assign lock_inc_s = (lock_cnt_q == LOCK_N) ? lock_cnt_q : (lock_cnt_q + LW'(1));

    // Stage 1: capture sign, magnitude and the T multiples in force for this sample.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q   <= 1'b0;
            s1_sign_re_q <= 1'b0;
            s1_sign_im_q <= 1'b0;
            s1_abs_re_q  <= 16'd0;
            s1_abs_im_q  <= 16'd0;
            s1_t1_q      <= 18'd0;
            s1_t2_q      <= 18'd0;
            s1_t3_q      <= 18'd0;
        end else begin
            s1_valid_q   <= bus.enable;
            s1_sign_re_q <= bus.in_real[15];
            s1_sign_im_q <= bus.in_imag[15];
            s1_abs_re_q  <= abs_re_s;
            s1_abs_im_q  <= abs_im_s;
            s1_t1_q      <= {2'b00, t_q};
            s1_t2_q      <= {1'b0, t_q, 1'b0};
            s1_t3_q      <= {2'b00, t_q} + {1'b0, t_q, 1'b0};
        end
    end

    // Stage 2: bin the magnitudes; invalid slots present all-zero codes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            real_q  <= 3'd0;
            imag_q  <= 3'd0;
            valid_q <= 1'b0;
        end else if (s1_valid_q) begin
            real_q  <= {s1_sign_re_q, quant_mag(s1_abs_re_q, s1_t1_q, s1_t2_q, s1_t3_q)};
            imag_q  <= {s1_sign_im_q, quant_mag(s1_abs_im_q, s1_t1_q, s1_t2_q, s1_t3_q)};
            valid_q <= 1'b1;
        end else begin
            real_q  <= 3'd0;
            imag_q  <= 3'd0;
            valid_q <= 1'b0;
        end
    end

    // AGC next state: manual override, window counting and per-window T adjustment.
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
        win_cnt_d  = win_cnt_q;
        evt_cnt_d  = evt_cnt_q;
        if (!bus.agc_enable) begin
            // Manual mode (and any partial window is discarded).
            state_d    = ST_IDLE;
            t_d        = bus.manual_thresh;
            locked_d   = 1'b0;
            lock_cnt_d = {LW{1'b0}};
            win_cnt_d  = {WIN_LOG2{1'b0}};
            evt_cnt_d  = {CW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Bumpless start: T keeps whatever manual value it had.
                    state_d    = ST_TRACK;
                    locked_d   = 1'b0;
                    lock_cnt_d = {LW{1'b0}};
                    win_cnt_d  = {WIN_LOG2{1'b0}};
                    evt_cnt_d  = {CW{1'b0}};
                end
                ST_TRACK, ST_LOCKED: begin
                    if (!valid_q) begin
                        // A gap in the sample stream restarts the window.
                        win_cnt_d = {WIN_LOG2{1'b0}};
                        evt_cnt_d = {CW{1'b0}};
                    end else if (&win_cnt_q) begin
                        win_cnt_d = {WIN_LOG2{1'b0}};
                        evt_cnt_d = {CW{1'b0}};
                        if (above_s || below_s) begin
                            // Even a step swallowed entirely by the clamp counts as an adjustment.
                            t_d        = above_s ? clamp_t(t_up_s) : clamp_t(t_dn_s);
                            lock_cnt_d = {LW{1'b0}};
                            state_d    = ST_TRACK;
                            locked_d   = 1'b0;
                        end else begin
                            lock_cnt_d = lock_inc_s;
                            if (lock_inc_s == LOCK_N) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                            end else begin
                                state_d  = state_q;
                                locked_d = locked_q;
                            end
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_LOG2'(1);
                        evt_cnt_d = evt_sum_s;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    locked_d   = 1'b0;
                    lock_cnt_d = {LW{1'b0}};
                    win_cnt_d  = {WIN_LOG2{1'b0}};
                    evt_cnt_d  = {CW{1'b0}};
                end
            endcase
        end
    end

    // AGC state registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            t_q        <= 16'(T_INIT);
            locked_q   <= 1'b0;
            lock_cnt_q <= {LW{1'b0}};
            win_cnt_q  <= {WIN_LOG2{1'b0}};
            evt_cnt_q  <= {CW{1'b0}};
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
            win_cnt_q  <= win_cnt_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign bus.real_out   = real_q;
    assign bus.imag_out   = imag_q;
    assign bus.out_valid  = valid_q;
    assign bus.thresh     = t_q;
    assign bus.agc_locked = locked_q;
endmodule

// File: tb/tb_gps_quantizer_agc.sv
// Scoreboard bench for gps_quantizer_agc: a sample-level reference model pushes the
// expected outputs each cycle; an independent monitor pops and compares on the falling edge.
module tb_gps_quantizer_agc;
    localparam int W      = 4;
    localparam int WIN    = 1 << W;
    localparam int T_INIT = 2048;
    localparam int T_MIN  = 16;
    localparam int T_MAX  = 32767;
    localparam int SSH    = 4;
    localparam int LOCKW  = 4;

    typedef struct { bit v; logic [2:0] re; logic [2:0] im; } smp_t;
    typedef struct { bit v; logic [2:0] re; logic [2:0] im; int thr; bit lk; } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    // reference model state
    int   m_T = T_INIT;
    bit   m_on = 1'b0;
    int   m_quiet = 0;
    int   m_n = 0;
    int   m_evts = 0;
    smp_t m_s1 = '{1'b0, 3'd0, 3'd0};
    smp_t m_s2 = '{1'b0, 3'd0, 3'd0};

    always #5 clk = ~clk;

    gps_quantizer_agc_if #(.WIN_LOG2(W)) bus ();

    gps_quantizer_agc #(
        .WIN_LOG2(W), .T_INIT(T_INIT), .T_MIN(T_MIN), .T_MAX(T_MAX),
        .STEP_SHIFT(SSH), .LOCK_WINDOWS(LOCKW)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Code = sign plus floor(|x|/T) limited to 3.
    function automatic logic [2:0] quant(int x, int t);
        int a;
        int m;
        a = (x < 0) ? -x : x;
        m = (t == 0) ? 3 : a / t;
        if (m > 3) m = 3;
        return {x < 0, m[1:0]};
    endfunction

    function automatic int rnd(int sh);
        int v;
        v = int'($urandom_range(0, 65535)) - 32768;
        return v >>> sh;
    endfunction

    // Advance the model across one clock edge using the inputs that were present before it.
    task automatic model_edge();
        smp_t old_s2;
        exp_t e;
        int   t_in, hi, lo, d, nt;
        bit   adj;
        old_s2 = m_s2;
        t_in   = m_T;
        if (rstn !== 1'b1) begin
            m_T = T_INIT; m_on = 1'b0; m_quiet = 0; m_n = 0; m_evts = 0;
            m_s1 = '{1'b0, 3'd0, 3'd0};
            m_s2 = '{1'b0, 3'd0, 3'd0};
        end else begin
            if (!bus.agc_enable) begin
                m_T = int'(bus.manual_thresh); m_on = 1'b0; m_quiet = 0; m_n = 0; m_evts = 0;
            end else if (!m_on) begin
                m_on = 1'b1; m_quiet = 0; m_n = 0; m_evts = 0;
            end else if (!old_s2.v) begin
                m_n = 0; m_evts = 0;
            end else begin
                m_n++;
                m_evts += (old_s2.re[1:0] == 2'b11) ? 1 : 0;
                m_evts += (old_s2.im[1:0] == 2'b11) ? 1 : 0;
                if (m_n == WIN) begin
                    hi = int'(bus.agc_target) + int'(bus.agc_hyst);
                    lo = int'(bus.agc_target) - int'(bus.agc_hyst);
                    if (lo < 0) lo = 0;
                    d = m_T / (1 << SSH);
                    if (d < 1) d = 1;
                    adj = 1'b1;
                    nt  = m_T;
                    if (m_evts > hi) nt = m_T + d;
                    else if (m_evts < lo) nt = m_T - d;
                    else adj = 1'b0;
                    if (adj) begin
                        if (nt < T_MIN) nt = T_MIN;
                        if (nt > T_MAX) nt = T_MAX;
                        m_T = nt;
                        m_quiet = 0;
                    end else begin
                        m_quiet++;
                    end
                    m_n = 0; m_evts = 0;
                end
            end
            m_s2 = m_s1;
            m_s1.v  = bus.enable;
            m_s1.re = bus.enable ? quant(int'(bus.in_real), t_in) : 3'd0;
            m_s1.im = bus.enable ? quant(int'(bus.in_imag), t_in) : 3'd0;
        end
        e.v   = m_s2.v;
        e.re  = m_s2.re;
        e.im  = m_s2.im;
        e.thr = m_T;
        e.lk  = m_on && (m_quiet >= LOCKW);
        exp_q.push_back(e);
    endtask

    task automatic step(bit en, int re, int im);
        @(posedge clk);
        #1;
        model_edge();
        bus.enable  = en;
        bus.in_real = 16'(re);
        bus.in_imag = 16'(im);
    endtask

    task automatic start_agc(int t0);
        bus.agc_enable    = 1'b0;
        bus.manual_thresh = 16'(t0);
        repeat (3) step(1'b0, 0, 0);
        bus.agc_enable = 1'b1;
        repeat (2) step(1'b0, 0, 0);
    endtask

    // Monitor: one expected entry per cycle, compared away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_valid",  int'(bus.out_valid),  int'(e.v));
                chk("real_out",   int'(bus.real_out),   int'(e.re));
                chk("imag_out",   int'(bus.imag_out),   int'(e.im));
                chk("thresh",     int'(bus.thresh),     e.thr);
                chk("agc_locked", int'(bus.agc_locked), int'(e.lk));
            end
        end
    end

    initial begin
        bus.enable = 1'b0; bus.in_real = 16'sd0; bus.in_imag = 16'sd0;
        bus.agc_enable = 1'b0; bus.manual_thresh = 16'd1000;
        bus.agc_target = 6'd10; bus.agc_hyst = 6'd2;

        // reset
        rstn = 1'b0;
        repeat (3) step(1'b0, 0, 0);
        chk("rst_thresh", int'(bus.thresh), 2048);
        chk("rst_valid",  int'(bus.out_valid), 0);
        chk("rst_locked", int'(bus.agc_locked), 0);
        rstn = 1'b1;
        step(1'b0, 0, 0);

        // manual mode, T=1000
        step(1'b1, 2500, -500);
        step(1'b1, 1000, 0);
        step(1'b1, 3000, -32768);
        chk("man_re_2500", int'(bus.real_out), 2);
        chk("man_im_m500", int'(bus.imag_out), 4);
        chk("man_valid",   int'(bus.out_valid), 1);
        step(1'b1, 0, 0);
        chk("man_re_1000", int'(bus.real_out), 1);
        step(1'b0, 0, 0);
        chk("man_re_3000", int'(bus.real_out), 3);
        chk("man_im_min",  int'(bus.imag_out), 7);
        step(1'b0, 0, 0);
        chk("man_re_zero", int'(bus.real_out), 0);
        chk("man_im_zero", int'(bus.imag_out), 0);
        step(1'b0, 0, 0);
        chk("man_gap_valid", int'(bus.out_valid), 0);

        // upward steps
        start_agc(2048);
        repeat (WIN) step(1'b1, 7000, 7000);
        repeat (4) step(1'b0, 0, 0);
        chk("up_win1", int'(bus.thresh), 2176);
        repeat (WIN) step(1'b1, 7000, 7000);
        repeat (4) step(1'b0, 0, 0);
        chk("up_win2", int'(bus.thresh), 2312);

        // lock
        start_agc(2048);
        repeat (3) begin
            repeat (10) step(1'b1, 7000, 0);
            repeat (6)  step(1'b1, 0, 0);
        end
        repeat (4) step(1'b0, 0, 0);
        chk("lock_w3", int'(bus.agc_locked), 0);
        repeat (10) step(1'b1, 7000, 0);
        repeat (6)  step(1'b1, 0, 0);
        repeat (4) step(1'b0, 0, 0);
        chk("lock_w4", int'(bus.agc_locked), 1);
        chk("lock_thr", int'(bus.thresh), 2048);

        // drop agc_enable mid-window while locked
        repeat (7) step(1'b1, 7000, 0);
        bus.agc_enable = 1'b0; bus.manual_thresh = 16'd1234;
        step(1'b1, 7000, 0);
        chk("drop_thr", int'(bus.thresh), 1234);
        chk("drop_lock", int'(bus.agc_locked), 0);

        // downward clamp at T_MIN
        start_agc(100);
        repeat (40 * WIN) step(1'b1, 0, 0);
        repeat (4) step(1'b0, 0, 0);
        chk("clamp_thr", int'(bus.thresh), 16);
        chk("clamp_lock", int'(bus.agc_locked), 0);

        // reset mid-window
        start_agc(3000);
        repeat (9) step(1'b1, rnd(2), rnd(2));
        rstn = 1'b0;
        step(1'b1, rnd(2), rnd(2));
        chk("mrst_thr",   int'(bus.thresh), 2048);
        chk("mrst_valid", int'(bus.out_valid), 0);
        chk("mrst_re",    int'(bus.real_out), 0);
        chk("mrst_im",    int'(bus.imag_out), 0);
        rstn = 1'b1;

        // enable gaps of 3 cycles
        repeat (6) begin
            repeat (5) step(1'b1, rnd(1), rnd(1));
            repeat (3) step(1'b0, rnd(1), rnd(1));
        end

        // randomized run
        begin
            int sh;
            sh = 2;
            bus.agc_target = 6'($urandom_range(0, 40));
            bus.agc_hyst   = 6'($urandom_range(0, 6));
            for (int i = 0; i < 4000; i++) begin
                if ((i % 64) == 0) sh = int'($urandom_range(0, 7));
                if ($urandom_range(0, 399) == 0) begin
                    bus.agc_enable    = ~bus.agc_enable;
                    bus.manual_thresh = 16'($urandom_range(0, 65535));
                    bus.agc_target    = 6'($urandom_range(0, 40));
                    bus.agc_hyst      = 6'($urandom_range(0, 6));
                end
                if ($urandom_range(0, 999) == 0) rstn = 1'b0;
                else rstn = 1'b1;
                step($urandom_range(0, 99) < 92, rnd(sh), rnd(sh));
            end
        end
        rstn = 1'b1;

        repeat (4) step(1'b0, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
